// File: rtl/clkdiv_ctrl_pkg.sv
// clkdiv_ctrl_pkg: shared state encoding, counter width and select-to-bit helper
package clkdiv_ctrl_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_e;

    // Divide select 00..11 picks counter bit 7..4 as the divided clock.
    function automatic logic [2:0] sel_bit(input logic [1:0] sel);
        return 3'd7 - {1'b0, sel};
    endfunction

endpackage

// File: rtl/clkdiv_pe_detect.sv
// clkdiv_pe_detect: period-end, wrap and divided-clock bit decode for a counter value
//   cnt_i       counter value
//   sel_i       divide select (00 -> /256 .. 11 -> /32)
//   pe_o        counter low bits [b:0] are all ones (last cycle of a dclk period)
//   wrap_o      counter is 8'hFF
//   next_dclk_o selected counter bit cnt_i[b]
module clkdiv_pe_detect
    import clkdiv_ctrl_pkg::*;
(
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [1:0]       sel_i,
    output logic             pe_o,
    output logic             wrap_o,
    output logic             next_dclk_o
);

    logic [CNT_W-1:0] mask;

    // Ones in bits [b:0]; bits above b are forced to 1 before the AND-reduce.
    assign mask        = 8'hFF >> sel_i;
    assign pe_o        = &(cnt_i | ~mask);
    assign wrap_o      = &cnt_i;
    assign next_dclk_o = cnt_i[sel_bit(sel_i)];

endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run/stop and glitch-free configuration controller for the 8-bit divided clock
//   clk_i    system clock
//   rstn_i   asynchronous active-low reset
//   req_i    configuration request (sel_i, burst_i)
//   sel_i    divide select: 00 /256, 01 /128, 10 /64, 11 /32
//   burst_i  dclk periods to emit, 0 = free-running
//   stop_i   stop request, executed at the next period end
//   ack_o    1-cycle pulse: configuration applied
//   busy_o   a configuration is waiting for the counter wrap
//   dclk_o   registered divided clock
//   tick_o   1-cycle pulse on the first high cycle of dclk_o
//   done_o   1-cycle pulse: burst completed or stop executed
module clkdiv_ctrl
    import clkdiv_ctrl_pkg::*;
#(
    parameter int BURST_W = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               req_i,
    input  logic [1:0]         sel_i,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               stop_i,
    output logic               ack_o,
    output logic               busy_o,
    output logic               dclk_o,
    output logic               tick_o,
    output logic               done_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sel_q, sel_d, shd_sel_q, shd_sel_d;
    logic [BURST_W-1:0] burst_q, burst_d, shd_burst_q, shd_burst_d;
    logic [BURST_W-1:0] pcnt_q, pcnt_d, pcnt_inc;
    logic               stop_pend_q, stop_pend_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d, done_q, done_d;
    logic               dclk_q, dclk_d, tick_q;
    logic               pe_q, wrap_q, pe_d, wrap_d, next_dclk;
    logic               burst_end;

    // Decode the next counter value so that pe/wrap flags and dclk all come
    // straight from flops in the cycle they describe.
    clkdiv_pe_detect u_pe (
        .cnt_i       (cnt_d),
        .sel_i       (sel_d),
        .pe_o        (pe_d),
        .wrap_o      (wrap_d),
        .next_dclk_o (next_dclk)
    );

    assign burst_end = pe_q && burst_q != '0 && pcnt_q == burst_q - BURST_W'(1);
    assign pcnt_inc  = &pcnt_q ? pcnt_q : pcnt_q + BURST_W'(1);
    assign dclk_d    = state_d != IDLE && next_dclk;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        burst_d     = burst_q;
        shd_sel_d   = shd_sel_q;
        shd_burst_d = shd_burst_q;
        pcnt_d      = pcnt_q;
        stop_pend_d = stop_pend_q;
        busy_d      = busy_q;
        ack_d       = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // A configuration left over from a burst that ended in PEND goes first.
                if (busy_q || req_i) begin
                    sel_d   = busy_q ? shd_sel_q : sel_i;
                    burst_d = busy_q ? shd_burst_q : burst_i;
                    pcnt_d  = '0;
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (burst_end || (pe_q && (stop_pend_q || stop_i))) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    stop_pend_d = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                    pcnt_d = pe_q ? pcnt_inc : pcnt_q;
                    // A stop (new or already pending) blocks any new request.
                    if (stop_i) begin
                        stop_pend_d = 1'b1;
                    end else if (req_i && !stop_pend_q) begin
                        shd_sel_d   = sel_i;
                        shd_burst_d = burst_i;
                        busy_d      = 1'b1;
                        state_d     = PEND;
                    end
                end
            end
            PEND: begin
                // Wrap beats a coinciding burst end: the new configuration starts.
                if (wrap_q) begin
                    sel_d   = shd_sel_q;
                    burst_d = shd_burst_q;
                    pcnt_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = RUN;
                end else if (burst_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                    pcnt_d = pe_q ? pcnt_inc : pcnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            burst_q     <= '0;
            shd_sel_q   <= '0;
            shd_burst_q <= '0;
            pcnt_q      <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            dclk_q      <= 1'b0;
            tick_q      <= 1'b0;
            pe_q        <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            burst_q     <= burst_d;
            shd_sel_q   <= shd_sel_d;
            shd_burst_q <= shd_burst_d;
            pcnt_q      <= pcnt_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            dclk_q      <= dclk_d;
            tick_q      <= dclk_d & ~dclk_q;
            pe_q        <= pe_d;
            wrap_q      <= wrap_d;
        end
    end

    assign ack_o  = ack_q;
    assign busy_o = busy_q;
    assign dclk_o = dclk_q;
    assign tick_o = tick_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: directed scenarios plus randomized traffic against a cycle-level model
module tb_clkdiv_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       req = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [7:0] burst = 8'd0;
    logic       stop = 1'b0;
    logic       ack, busy, dclk, tick, done;

    clkdiv_ctrl #(.BURST_W(8)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .req_i   (req),
        .sel_i   (sel),
        .burst_i (burst),
        .stop_i  (stop),
        .ack_o   (ack),
        .busy_o  (busy),
        .dclk_o  (dclk),
        .tick_o  (tick),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    bit  armed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: states 0 idle, 1 run, 2 pending config.
    int m_state = 0, m_cnt = 0, m_sel = 0, m_burst = 0, m_pcnt = 0, m_ssel = 0, m_sburst = 0, m_per;
    bit m_stp = 0, m_busy = 0, m_pe, m_bend, m_prev;
    bit e_ack = 0, e_busy = 0, e_dclk = 0, e_tick = 0, e_done = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_state = 0; m_cnt = 0; m_sel = 0; m_burst = 0; m_pcnt = 0; m_ssel = 0; m_sburst = 0;
            m_stp = 0; m_busy = 0;
            e_ack = 0; e_busy = 0; e_dclk = 0; e_tick = 0; e_done = 0;
        end else begin
            m_per  = 256 >> m_sel;
            m_pe   = ((m_cnt + 1) % m_per) == 0;
            m_bend = m_pe && m_burst != 0 && m_pcnt == m_burst - 1;
            m_prev = e_dclk;
            e_ack  = 0;
            e_done = 0;
            if (m_state == 0) begin
                if (m_busy) begin
                    m_sel = m_ssel; m_burst = m_sburst; m_pcnt = 0; m_busy = 0; e_ack = 1; m_state = 1;
                end else if (req) begin
                    m_sel = int'(sel); m_burst = int'(burst); m_pcnt = 0; e_ack = 1; m_state = 1;
                end
            end else if (m_state == 2 && m_cnt == 255) begin
                m_sel = m_ssel; m_burst = m_sburst; m_pcnt = 0; m_cnt = 0; m_busy = 0; e_ack = 1; m_state = 1;
            end else if (m_bend || (m_state == 1 && m_pe && (m_stp || stop))) begin
                m_state = 0; m_cnt = 0; m_stp = 0; e_done = 1;
            end else begin
                m_cnt = (m_cnt + 1) % 256;
                if (m_pe && m_pcnt < 255) m_pcnt++;
                if (m_state == 1) begin
                    if (stop) m_stp = 1;
                    else if (req && !m_stp) begin
                        m_ssel = int'(sel); m_sburst = int'(burst); m_busy = 1; m_state = 2;
                    end
                end
            end
            e_busy = m_busy;
            m_per  = 256 >> m_sel;
            e_dclk = m_state != 0 && (m_cnt % m_per) >= m_per / 2;
            e_tick = e_dclk && !m_prev;
        end
    end

    int shown = 0;
    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if ({ack, busy, dclk, tick, done} !== {e_ack, e_busy, e_dclk, e_tick, e_done}) begin
                failures++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL model t=%0t ack/busy/dclk/tick/done got %b%b%b%b%b expected %b%b%b%b%b",
                             $time, ack, busy, dclk, tick, done, e_ack, e_busy, e_dclk, e_tick, e_done);
                end
            end
        end
    end

    // Event monitor for the directed scenarios.
    int cyc = 0, hi_n = 0, busy_n = 0;
    int ack_t[$], done_t[$], tick_t[$], edge_t[$];
    logic dclk_prev = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (ack)  ack_t.push_back(cyc);
        if (done) done_t.push_back(cyc);
        if (tick) tick_t.push_back(cyc);
        if (dclk !== dclk_prev) edge_t.push_back(cyc);
        if (dclk) hi_n++;
        if (busy) busy_n++;
        dclk_prev = dclk;
    end

    task automatic clr();
        ack_t.delete(); done_t.delete(); tick_t.delete(); edge_t.delete();
        hi_n = 0; busy_n = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit r, input logic [1:0] s, input logic [7:0] b, input bit st);
        req = r; sel = s; burst = b; stop = st;
        step(1);
        req = 0; stop = 0;
    endtask

    function automatic int min_gap();
        int m = 1 << 30;
        for (int i = 1; i < edge_t.size(); i++)
            if (edge_t[i] - edge_t[i-1] < m) m = edge_t[i] - edge_t[i-1];
        return m;
    endfunction

    initial begin
        step(3);
        rstn = 1;
        armed = 1;
        step(2);

        // Reset in mid-count, then idle with dclk low.
        pulse(1, 2'd3, 8'd0, 0);
        step(20);
        chk("pre_reset_dclk", int'(dclk), 1);
        rstn = 0;
        #2;
        chk("reset_outputs", int'({ack, busy, dclk, tick, done}), 0);
        step(3);
        rstn = 1;
        step(5);
        chk("post_reset_outputs", int'({ack, busy, dclk, tick, done}), 0);

        // Burst of two /32 periods.
        clr();
        pulse(1, 2'd3, 8'd2, 0);
        step(80);
        chk("b2_acks", ack_t.size(), 1);
        chk("b2_ticks", tick_t.size(), 2);
        chk("b2_hi_cycles", hi_n, 32);
        if (ack_t.size() == 1 && done_t.size() == 1 && tick_t.size() == 2) begin
            chk("b2_done_lat", done_t[0] - ack_t[0], 64);
            chk("b2_first_tick", tick_t[0] - ack_t[0], 16);
            chk("b2_tick_period", tick_t[1] - tick_t[0], 32);
        end else chk("b2_event_counts", done_t.size(), 1 + 100);

        // Free-running /256 with stop at cnt=40 of the second period.
        clr();
        pulse(1, 2'd0, 8'd0, 0);
        step(296);
        pulse(0, 2'd0, 8'd0, 1);
        step(300);
        chk("fr_ticks", tick_t.size(), 2);
        chk("fr_hi_cycles", hi_n, 256);
        chk("fr_dclk_after_stop", int'(dclk), 0);
        if (ack_t.size() == 1 && done_t.size() == 1 && tick_t.size() == 2) begin
            chk("fr_period", tick_t[1] - tick_t[0], 256);
            chk("fr_first_tick", tick_t[0] - ack_t[0], 128);
            chk("fr_done_lat", done_t[0] - ack_t[0], 512);
        end else chk("fr_event_counts", done_t.size(), 1 + 100);

        // Select change /32 -> /256 requested at cnt=100.
        clr();
        pulse(1, 2'd3, 8'd0, 0);
        step(100);
        pulse(1, 2'd0, 8'd0, 0);
        step(700);
        chk("sw_acks", ack_t.size(), 2);
        chk("sw_busy_cycles", busy_n, 155);
        chk("sw_min_phase_ok", int'(min_gap() >= 16), 1);
        if (ack_t.size() == 2 && tick_t.size() >= 2) begin
            chk("sw_ack_gap", ack_t[1] - ack_t[0], 256);
            chk("sw_new_period", tick_t[$] - tick_t[$-1], 256);
        end else chk("sw_event_counts", ack_t.size(), 2 + 100);
        pulse(0, 2'd0, 8'd0, 1);
        step(300);

        // Second request while pending is ignored.
        clr();
        pulse(1, 2'd3, 8'd0, 0);
        step(50);
        pulse(1, 2'd0, 8'd0, 0);
        step(10);
        pulse(1, 2'd2, 8'd0, 0);
        step(700);
        chk("pend_acks", ack_t.size(), 2);
        if (tick_t.size() >= 2) chk("pend_period", tick_t[$] - tick_t[$-1], 256);
        else chk("pend_ticks", tick_t.size(), 2);
        pulse(0, 2'd0, 8'd0, 1);
        step(300);

        // req together with stop: stop wins.
        clr();
        pulse(1, 2'd3, 8'd0, 0);
        step(20);
        pulse(1, 2'd0, 8'd0, 1);
        step(30);
        chk("rs_acks", ack_t.size(), 1);
        chk("rs_busy_cycles", busy_n, 0);
        if (ack_t.size() == 1 && done_t.size() == 1) chk("rs_done_lat", done_t[0] - ack_t[0], 32);
        else chk("rs_dones", done_t.size(), 1);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 20000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            req   = (r < 20);
            stop  = (r >= 15 && r < 28);
            sel   = 2'($urandom);
            burst = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            if (r == 999) begin
                req = 0; stop = 0;
                rstn = 0;
                step(2);
                rstn = 1;
            end
            step(1);
        end
        req = 0; stop = 0;
        step(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
